// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - parametrised single-clock FIFO with exact count, thresholds and optional FWFT
//
// Ports:
//   clock        rising-edge clock
//   reset        asynchronous active-high reset
//   wr_en        write request; data_in is stored when accepted
//   data_in      write data
//   rd_en        read request (FWFT: acknowledge/pop of the presented head word)
//   data_out     read data (never tri-stated)
//   data_valid   data_out carries a valid word
//   full/empty   count == DEPTH / count == 0
//   almost_full  count >= AF_LEVEL
//   almost_empty count <= AE_LEVEL
//   count        exact occupancy 0..DEPTH
//   overflow     one-cycle pulse after a rejected write
//   underflow    one-cycle pulse after a rejected read
module sync_fifo_param #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 128,
  parameter int FWFT     = 0,
  parameter int AF_LEVEL = DEPTH - 4,
  parameter int AE_LEVEL = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         wr_en,
  input  logic [WIDTH-1:0]             data_in,
  input  logic                         rd_en,
  output logic [WIDTH-1:0]             data_out,
  output logic                         data_valid,
  output logic                         full,
  output logic                         empty,
  output logic                         almost_full,
  output logic                         almost_empty,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
  localparam logic [CW-1:0] C_AF    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] C_AE    = CW'(AE_LEVEL);
  localparam logic [PW-1:0] P_LAST  = PW'(DEPTH - 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_overflow;
  logic             r_underflow;

  logic             w_full;
  logic             w_empty;
  logic             w_rd_acc;
  logic             w_wr_acc;

  // Explicit wrap compare so non-power-of-2 depths work.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == P_LAST) ? '0 : p + PW'(1);
  endfunction

  assign w_full   = (r_count == C_DEPTH);
  assign w_empty  = (r_count == '0);
  assign w_rd_acc = rd_en & ~w_empty;
  // A write into a full FIFO is still accepted when a read frees a slot the same cycle.
  assign w_wr_acc = wr_en & (~w_full | w_rd_acc);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= wr_en & ~w_wr_acc;
      r_underflow <= rd_en & ~w_rd_acc;
      if (w_wr_acc) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_rd_acc) r_rd_ptr <= next_ptr(r_rd_ptr);
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clock) begin
    if (w_wr_acc) r_mem[r_wr_ptr] <= data_in;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is presented continuously; rd_en only pops it.
      assign data_out   = r_mem[r_rd_ptr];
      assign data_valid = ~w_empty;
    end else begin : g_std
      logic [WIDTH-1:0] r_data_out;
      logic             r_data_valid;
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          r_data_out   <= '0;
          r_data_valid <= 1'b0;
        end else begin
          r_data_valid <= w_rd_acc;
          if (w_rd_acc) r_data_out <= r_mem[r_rd_ptr];
        end
      end
      assign data_out   = r_data_out;
      assign data_valid = r_data_valid;
    end
  endgenerate

  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (r_count >= C_AF);
  assign almost_empty = (r_count <= C_AE);
  assign count        = r_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule
